multi_one_shot: RTL
===================

Name: multi_one_shot

Overview:
- Parametrised successor to the single-button one-shot.
- Takes CHANNELS asynchronous push-button inputs and, per channel:
  - synchronises the input (2-FF);
  - debounces it with a stable-count filter;
  - emits a single-cycle pulse on the selected debounced edge(s).
- Sits between board buttons and counter/FSM logic that needs exactly one event per press.

Parameters:
- CHANNELS, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 8, consecutive equal synchronised samples needed to accept a level change (>=2).
- EDGE_MODE, 0, pulse source: 0 = debounced press (rise), 1 = debounced release (fall), 2 = both.
- REPEAT_DELAY, 64, cycles held before first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button  input  CHANNELS  raw active-high buttons, asynchronous to clk.
- one_shot_button  output  CHANNELS  registered one-cycle pulse per channel.
- button_level  output  CHANNELS  registered debounced level per channel.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0:
  - sync FFs, counters and FSMs are cleared;
  - FSMs sit in IDLE;
  - one_shot_button = 0 and button_level = 0.
- Reset release: first evaluation on the next rising clk edge.
- Reset asserted mid-debounce or mid-press: pending event is discarded; no pulse is produced.
- Per-channel FSM, fully independent; s = synchronised input (2 FF stages).
  - IDLE (level 0): if s=1 → DEB_PRESS, cnt=1; else stay.
  - DEB_PRESS:
    - s=0 → IDLE, cnt=0 (glitch rejected, no pulse);
    - s=1 and cnt=DEBOUNCE_CYCLES-1 → PRESSED, button_level←1, rise event;
    - otherwise cnt++.
  - PRESSED (level 1): if s=0 → DEB_RELEASE, cnt=1; else stay.
  - DEB_RELEASE:
    - s=1 → PRESSED, cnt=0;
    - s=0 and cnt=DEBOUNCE_CYCLES-1 → IDLE, button_level←0, fall event;
    - otherwise cnt++.
- Pulse generation:
  - one_shot_button[i] is high for exactly one cycle on the edge following a rise event (EDGE_MODE 0/2) or a fall event (EDGE_MODE 1/2).
  - It can never be high in two consecutive cycles except via auto-repeat (not possible, since REPEAT_PERIOD>=2 is enforced).
- Latency: edge 0 is the first rising edge at which button=1 is sampled and held.
  - button_level and the press pulse go high after edge DEBOUNCE_CYCLES+1.
  - Release is symmetric.
- Counter width: $clog2(REPEAT_DELAY+1) or $clog2(DEBOUNCE_CYCLES), whichever is larger.
- Counter saturates and never wraps.
- Holding a button indefinitely produces one pulse only (without AUTOREPEAT_EN).
- Simultaneous events on multiple channels produce simultaneous pulses; there is no arbitration.
- Illegal EDGE_MODE (>2) behaves as 0.

Optional Feature:
- Macro: MULTI_ONE_SHOT_AUTOREPEAT_EN.
- Defined:
  - in PRESSED, a per-channel hold counter starts at the press pulse;
  - an extra one-cycle pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while PRESSED;
  - entering DEB_RELEASE freezes the hold counter; a bounce back to PRESSED resumes it;
  - reaching IDLE clears it;
  - repeat pulses apply only when EDGE_MODE is 0 or 2.
- Not defined: no hold counter logic is synthesised; a held button yields exactly one press pulse.

Test Plan:
- Reset and default parameters:
  - apply rst_n=0 with button=4'hF → outputs stay 0;
  - release reset with buttons held → single pulse on all 4 channels after edge 9, button_level=4'hF.
- Latency check:
  - DEBOUNCE_CYCLES=4, EDGE_MODE=0; button[0] rises and holds 100 cycles → one_shot_button[0] high for exactly one cycle after edge 5;
  - no further pulses; button_level[0] stays 1.
- Bounce rejection: button[1] toggles 1,0,1,0 each cycle for 20 cycles, then stays 0 → no pulse, button_level[1]=0.
- Release mode:
  - EDGE_MODE=1, press then release button[2] (each held 50 cycles) → no pulse on press;
  - one pulse DEBOUNCE_CYCLES+2 cycles after release.
- Mid-operation reset: assert rst_n=0 while button[3] is in DEB_PRESS, then release with button still held → pulse only after a full new debounce window.
- With MULTI_ONE_SHOT_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold 30 cycles → pulses at press, press+10, +14, +18, +22, +26; none after release.

Source files
------------

// File: rtl/multi_one_shot_if.sv
// multi_one_shot_if: button bundle between board-level buttons and the one-shot block.
// The master drives the raw buttons; the slave returns per-channel pulses and debounced levels.
interface multi_one_shot_if #(
  parameter int unsigned CHANNELS = 4
) ();
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] one_shot_button;
  logic [CHANNELS-1:0] button_level;

  modport master (
    output button,
    input  one_shot_button,
    input  button_level
  );

  modport slave (
    input  button,
    output one_shot_button,
    output button_level
  );
endinterface

// File: rtl/multi_one_shot.sv
// multi_one_shot: per-channel 2-FF synchroniser, stable-count debouncer and single-cycle
// edge pulse generator. Define MULTI_ONE_SHOT_AUTOREPEAT_EN to add auto-repeat pulses
// while a button is held (press-edge modes only).
module multi_one_shot #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input logic             clk,
  input logic             rst_n,
  multi_one_shot_if.slave bus
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned CntW = (RepW > DebW) ? RepW : DebW;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  // Any EDGE_MODE other than 1 (release only) pulses on press; >2 thus falls back to 0.
  localparam bit RiseEn = (EDGE_MODE != 1);
  localparam bit FallEn = (EDGE_MODE == 1) || (EDGE_MODE == 2);

`ifdef MULTI_ONE_SHOT_AUTOREPEAT_EN
  localparam int unsigned RepPeriod = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam int unsigned HoldWa    = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned HoldWb    = $clog2(RepPeriod + 1);
  localparam int unsigned HoldW     = (HoldWa > HoldWb) ? HoldWa : HoldWb;
  localparam logic [HoldW-1:0] HoldFirst = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] HoldNext  = HoldW'(RepPeriod - 1);
  localparam logic [HoldW-1:0] HoldMax   = '1;
`endif

  typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRelease} state_e;

  logic [CHANNELS-1:0] r_sync1, r_sync2;
  logic [CHANNELS-1:0] w_pulse_all, w_level_all;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            w_s, w_rise, w_fall, w_rep;
    logic            r_pulse, r_level, w_pulse_d, w_level_d;

    assign w_s = r_sync2[g];

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_level <= 1'b0;
      end else begin
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
        r_pulse <= w_pulse_d;
        r_level <= w_level_d;
      end
    end

    // Next state: a level change needs DEBOUNCE_CYCLES consecutive opposite samples.
    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_rise    = 1'b0;
      w_fall    = 1'b0;
      case (r_state)
        StIdle: begin
          if (w_s) begin
            w_state_d = StDebPress;
            w_cnt_d   = CntW'(1);
          end
        end
        StDebPress: begin
          if (!w_s) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else if (r_cnt >= CntLast) begin
            w_state_d = StPressed;
            w_cnt_d   = '0;
            w_rise    = 1'b1;
          end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        StPressed: begin
          if (!w_s) begin
            w_state_d = StDebRelease;
            w_cnt_d   = CntW'(1);
          end
        end
        StDebRelease: begin
          if (w_s) begin
            w_state_d = StPressed;
            w_cnt_d   = '0;
          end else if (r_cnt >= CntLast) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_fall    = 1'b1;
          end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end

    // Outputs: level follows the accepted state, pulse marks the selected edge(s).
    always_comb begin
      w_level_d = (w_state_d == StPressed) || (w_state_d == StDebRelease);
      w_pulse_d = (RiseEn && w_rise) || (FallEn && w_fall) || (RiseEn && w_rep);
    end

`ifdef MULTI_ONE_SHOT_AUTOREPEAT_EN
    logic [HoldW-1:0] r_hold, w_hold_d;
    logic             r_rep_phase, w_rep_phase_d;

    // Hold timer: advances only while staying PRESSED, frozen during release debounce.
    always_comb begin
      w_hold_d      = r_hold;
      w_rep_phase_d = r_rep_phase;
      w_rep         = 1'b0;
      if (w_state_d == StIdle || w_rise) begin
        w_hold_d      = '0;
        w_rep_phase_d = 1'b0;
      end else if (r_state == StPressed && w_state_d == StPressed) begin
        if (!r_rep_phase && r_hold == HoldFirst) begin
          w_rep         = 1'b1;
          w_hold_d      = '0;
          w_rep_phase_d = 1'b1;
        end else if (r_rep_phase && r_hold == HoldNext) begin
          w_rep    = 1'b1;
          w_hold_d = '0;
        end else if (r_hold != HoldMax) begin
          w_hold_d = r_hold + HoldW'(1);
        end
      end
    end

    // Hold timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold      <= '0;
        r_rep_phase <= 1'b0;
      end else begin
        r_hold      <= w_hold_d;
        r_rep_phase <= w_rep_phase_d;
      end
    end
`else
    assign w_rep = 1'b0;
`endif

    assign w_pulse_all[g] = r_pulse;
    assign w_level_all[g] = r_level;
  end

  assign bus.one_shot_button = w_pulse_all;
  assign bus.button_level    = w_level_all;

endmodule
